// File: rtl/simd_wb_queue.sv
// Writeback queue for the SIMD integer unit: tracks each issued op's tag for LAT
// cycles, captures the untagged result on its return cycle into a small FIFO, and
// stalls issue so that a returning result always finds a free slot.
module simd_wb_queue #(
   parameter int DEPTH = 4,
   parameter int LAT   = 2,
   parameter int TAGW  = 9,
   parameter int WIDTH = 68
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_en,
   input  logic [TAGW-1:0]          in_tag,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         simd_res,
   output logic                     issue_stall,
   output logic                     wb_valid,
   output logic [WIDTH-1:0]         wb_data,
   output logic [TAGW-1:0]          wb_tag,
   input  logic                     wb_ready,
   output logic                     ovf_err,
   output logic [$clog2(DEPTH):0]   occ
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   // Wide enough for occ + inflight, which can reach DEPTH + LAT.
   localparam int SW = $clog2(DEPTH + LAT + 1);

   logic [LAT-1:0]   pipe_vld;
   logic [TAGW-1:0]  pipe_tag [LAT];
   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [TAGW-1:0]  tag_mem  [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [OW-1:0]    occ_q;
   logic             ovf_q;
   logic [SW-1:0]    inflight;
   logic [SW-1:0]    load;
   logic             issue_ok;
   logic             push;
   logic             pop;

   // Count ops still travelling through the SIMD unit.
   always_comb begin
      // NOTE: assigning a default before the loop keeps this purely combinational;
      // any path that leaves a variable unassigned in always_comb infers a latch.
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + SW'(pipe_vld[i]);
      end
   end

   // Stall looks only at registered state, so it is one cycle conservative on pops.
   assign load        = SW'(occ_q) + inflight;
   assign issue_stall = (load >= SW'(DEPTH));

   assign issue_ok = in_en & ~issue_stall & ~flush;
   assign push     = pipe_vld[LAT-1] & ~flush;
   assign wb_valid = (occ_q != '0);
   assign pop      = wb_valid & wb_ready & ~flush;

   // Tag shift register mirroring the unit's fixed latency.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: all state here uses non-blocking assignment so every stage reads the
      // previous cycle's value of its neighbour, giving a true shift register.
      if (!rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            pipe_tag[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= issue_ok;
         pipe_tag[0] <= in_tag;
         for (int i = 1; i < LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1] & ~flush;
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   // Result storage, written on the return cycle of a tracked op.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; entries are only ever
      // observed through wb_valid, so clearing it would buy nothing.
      if (push) begin
         data_mem[wr_ptr] <= simd_res;
         tag_mem[wr_ptr]  <= pipe_tag[LAT-1];
      end
   end

   // FIFO pointers and occupancy counter; occ is kept independently of the pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OW'(1);
            2'b01:   occ_q <= occ_q - OW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Sticky flag for an issue attempted against the stall; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (in_en && issue_stall) begin
         ovf_q <= 1'b1;
      end
   end

   assign wb_data = wb_valid ? data_mem[rd_ptr] : '0;
   assign wb_tag  = wb_valid ? tag_mem[rd_ptr]  : '0;
   assign ovf_err = ovf_q;
   assign occ     = occ_q;

endmodule

// File: tb/tb_simd_wb_queue.sv
// Bench for simd_wb_queue: directed stimulus, a queue-based model of the issue /
// return / writeback behaviour, a per-cycle compare process and literal checkpoints.
module tb_simd_wb_queue;

   localparam int DEPTH = 4;
   localparam int LAT   = 2;
   localparam int TAGW  = 9;
   localparam int WIDTH = 68;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic             in_en;
   logic [TAGW-1:0]  in_tag;
   logic             flush;
   logic [WIDTH-1:0] simd_res;
   logic             issue_stall;
   logic             wb_valid;
   logic [WIDTH-1:0] wb_data;
   logic [TAGW-1:0]  wb_tag;
   logic             wb_ready;
   logic             ovf_err;
   logic [OW-1:0]    occ;

   simd_wb_queue #(.DEPTH(DEPTH), .LAT(LAT), .TAGW(TAGW), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_en       (in_en),
      .in_tag      (in_tag),
      .flush       (flush),
      .simd_res    (simd_res),
      .issue_stall (issue_stall),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .wb_tag      (wb_tag),
      .wb_ready    (wb_ready),
      .ovf_err     (ovf_err),
      .occ         (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TAGW-1:0]  tag;
      logic [WIDTH-1:0] data;
      int               due;
   } op_t;

   // Model state: ops inside the unit (with their return cycle) and queued results.
   op_t              m_inflight[$];
   op_t              m_fifo[$];
   bit               m_ovf;
   int               cyc;
   logic [WIDTH-1:0] cur_data;
   int               n_checks;
   int               n_errors;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] mk(input logic [TAGW-1:0] t);
      return {t, ~t, 50'h3_0000_0000_0000 + 50'(t)};
   endfunction

   function automatic bit m_stall();
      return (m_fifo.size() + m_inflight.size()) >= DEPTH;
   endfunction

   task automatic model_reset();
      m_inflight.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
      cyc   = 0;
   endtask

   // Advance the model across one rising edge using the inputs held for that cycle.
   task automatic model_step();
      bit  stall;
      op_t op;
      if (rst) begin
         stall = m_stall();
         if (in_en && stall) m_ovf = 1'b1;
         if (flush) begin
            m_inflight.delete();
            m_fifo.delete();
         end else begin
            if (wb_ready && m_fifo.size() != 0) m_fifo.delete(0);
            if (m_inflight.size() != 0 && m_inflight[0].due == cyc) begin
               m_fifo.push_back(m_inflight[0]);
               m_inflight.delete(0);
            end
            if (in_en && !stall) begin
               op.tag  = in_tag;
               op.data = cur_data;
               op.due  = cyc + LAT;
               m_inflight.push_back(op);
            end
         end
         cyc++;
      end
   endtask

   // The unit returns the op's result on its due cycle; any other cycle carries junk.
   task automatic drive_res();
      if (rst && m_inflight.size() != 0 && m_inflight[0].due == cyc)
         simd_res = m_inflight[0].data;
      else
         simd_res = WIDTH'({$urandom, $urandom, $urandom});
   endtask

   task automatic tick(input logic en, input logic [TAGW-1:0] tag,
                       input logic [WIDTH-1:0] data, input logic rdy, input logic fl);
      in_en    = en;
      in_tag   = tag;
      cur_data = data;
      wb_ready = rdy;
      flush    = fl;
      drive_res();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      tick(1'b0, '0, '0, rdy, 1'b0);
   endtask

   // Compare every DUT output with the model, away from the active edge.
   always @(negedge clk) begin
      check("wb_valid", WIDTH'(wb_valid), WIDTH'(m_fifo.size() != 0));
      check("occ", WIDTH'(occ), WIDTH'(m_fifo.size()));
      check("issue_stall", WIDTH'(issue_stall), WIDTH'(m_stall()));
      check("ovf_err", WIDTH'(ovf_err), WIDTH'(m_ovf));
      if (m_fifo.size() != 0) begin
         check("wb_tag", WIDTH'(wb_tag), WIDTH'(m_fifo[0].tag));
         check("wb_data", wb_data, m_fifo[0].data);
      end else begin
         check("wb_tag_idle", WIDTH'(wb_tag), '0);
         check("wb_data_idle", wb_data, '0);
      end
   end

   initial begin
      rst      = 1'b0;
      in_en    = 1'b0;
      in_tag   = '0;
      flush    = 1'b0;
      wb_ready = 1'b0;
      simd_res = '0;
      cur_data = '0;
      n_checks = 0;
      n_errors = 0;
      model_reset();

      // Reset state
      @(negedge clk);
      check("rst_wb_valid", WIDTH'(wb_valid), '0);
      check("rst_stall", WIDTH'(issue_stall), '0);
      check("rst_occ", WIDTH'(occ), '0);
      check("rst_ovf", WIDTH'(ovf_err), '0);
      check("rst_wb_data", wb_data, '0);
      check("rst_wb_tag", WIDTH'(wb_tag), '0);
      rst = 1'b1;

      // Single op: issue cycle 0, visible cycle 3, gone cycle 4
      tick(1'b1, 9'h1A5, 68'h0_1234_5678_9ABC_DEF0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("single_valid", WIDTH'(wb_valid), WIDTH'(1));
      check("single_tag", WIDTH'(wb_tag), WIDTH'(9'h1A5));
      check("single_data", wb_data, 68'h0_1234_5678_9ABC_DEF0);
      check("single_occ", WIDTH'(occ), WIDTH'(1));
      idle(1'b1);
      check("single_gone", WIDTH'(wb_valid), '0);
      check("single_occ0", WIDTH'(occ), '0);

      // Fill with writeback blocked
      for (int i = 1; i <= 4; i++) tick(1'b1, TAGW'(i), mk(TAGW'(i)), 1'b0, 1'b0);
      check("fill_stall_c4", WIDTH'(issue_stall), WIDTH'(1));
      idle(1'b0);
      idle(1'b0);
      check("fill_occ_c6", WIDTH'(occ), WIDTH'(4));
      check("fill_stall_c6", WIDTH'(issue_stall), WIDTH'(1));

      // Issue against the stall
      tick(1'b1, 9'h1FF, mk(9'h1FF), 1'b0, 1'b0);
      check("ovf_set", WIDTH'(ovf_err), WIDTH'(1));
      check("ovf_occ", WIDTH'(occ), WIDTH'(4));

      // Drain in order
      for (int i = 1; i <= 4; i++) begin
         check("drain_tag", WIDTH'(wb_tag), WIDTH'(i));
         idle(1'b1);
      end
      check("drain_occ", WIDTH'(occ), '0);
      check("drain_valid", WIDTH'(wb_valid), '0);
      check("ovf_sticky", WIDTH'(ovf_err), WIDTH'(1));

      // Streaming with simultaneous push/pop across pointer wrap
      for (int i = 0; i < 12; i++) begin
         if (i == 6) begin
            check("stream_occ", WIDTH'(occ), WIDTH'(1));
            check("stream_stall", WIDTH'(issue_stall), '0);
            check("stream_tag", WIDTH'(wb_tag), WIDTH'(9'h013));
         end
         tick(1'b1, TAGW'(9'h010 + i), mk(TAGW'(9'h010 + i)), 1'b1, 1'b0);
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      check("stream_done", WIDTH'(occ), '0);

      // Flush with two results queued and two still in the unit
      for (int i = 0; i < 4; i++) tick(1'b1, TAGW'(9'h020 + i), mk(TAGW'(9'h020 + i)), 1'b0, 1'b0);
      check("preflush_occ", WIDTH'(occ), WIDTH'(2));
      check("preflush_stall", WIDTH'(issue_stall), WIDTH'(1));
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      check("flush_occ", WIDTH'(occ), '0);
      check("flush_valid", WIDTH'(wb_valid), '0);
      check("flush_stall", WIDTH'(issue_stall), '0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      check("postflush_occ", WIDTH'(occ), '0);
      check("flush_keeps_ovf", WIDTH'(ovf_err), WIDTH'(1));
      // An issue in the flush cycle is discarded
      tick(1'b1, 9'h02A, mk(9'h02A), 1'b0, 1'b1);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);
      check("flush_issue_dropped", WIDTH'(occ), '0);

      // Asynchronous reset between edges
      tick(1'b1, 9'h030, mk(9'h030), 1'b0, 1'b0);
      tick(1'b1, 9'h031, mk(9'h031), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("prereset_occ", WIDTH'(occ), WIDTH'(2));
      in_en = 1'b0;
      drive_res();
      @(posedge clk);
      model_step();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("arst_valid", WIDTH'(wb_valid), '0);
      check("arst_stall", WIDTH'(issue_stall), '0);
      check("arst_occ", WIDTH'(occ), '0);
      check("arst_ovf", WIDTH'(ovf_err), '0);
      @(negedge clk);
      rst = 1'b1;

      // First op after reset release
      tick(1'b1, 9'h0C3, 68'h0_1234_5678_9ABC_DEF0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("rel_valid", WIDTH'(wb_valid), WIDTH'(1));
      check("rel_tag", WIDTH'(wb_tag), WIDTH'(9'h0C3));
      check("rel_data", wb_data, 68'h0_1234_5678_9ABC_DEF0);
      idle(1'b1);
      check("rel_gone", WIDTH'(wb_valid), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
